// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: FSM state encodings, the I/O region base and the access size codes.
package mem_ctrl_pkg;

   localparam logic [1:0] MEM_IDLE  = 2'd0;
   localparam logic [1:0] MEM_LOAD  = 2'd1;
   localparam logic [1:0] MEM_STORE = 2'd2;
   localparam logic [1:0] MEM_FETCH = 2'd3;

   localparam logic [31:0] IO_REGION = 32'h0003_0000;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // Index of the final byte of an access (byte count minus one).
   function automatic logic [1:0] last_byte(input logic [1:0] size);
      case (size)
         SIZE_B:  return 2'd0;
         SIZE_H:  return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ext.sv
// Combinational sign/zero extender for byte and half-word loads; op[2] selects zero extension.
module mem_ext
   import mem_ctrl_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  op,
   output logic [31:0] res
);

   always_comb begin
      case (op[1:0])
         SIZE_B:  res = {{24{raw[7] & ~op[2]}}, raw[7:0]};
         SIZE_H:  res = {{16{raw[15] & ~op[2]}}, raw[15:0]};
         default: res = raw;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises LSB loads/stores and 32-bit fetches onto an 8-bit RAM port.
// Optional MEM_IOBUF_STALL_EN: store bytes to the 0x30000 I/O region wait while io_buffer_full is high.
//   state     | meaning
//   MEM_IDLE  | no access in flight; completion pulses are driven here
//   MEM_LOAD  | LSB load, one byte address presented per cycle
//   MEM_STORE | LSB store, one byte written per cycle (runs to completion)
//   MEM_FETCH | instruction fetch, four byte addresses
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   input  logic        is_io,
   input  logic        is_store,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_data,
   input  logic [2:0]  io_op,
   output logic        mem_res_avail,
   output logic [31:0] mem_res,
   output logic        mem_stuck,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_res_avail,
   output logic [31:0] if_res,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   logic [1:0]  state;
   logic [2:0]  cnt;
   logic [1:0]  last_q;
   logic [2:0]  op_q;
   logic [31:0] data_q;
   logic [31:0] raw;
   logic [31:0] assembled;
   logic [31:0] ext_res;
   logic [1:0]  cap_idx;
   logic        din_vld;
   logic        wr_q;
   logic        kill_q;
   logic        res_avail_q;
   logic        res_load_q;
   logic        if_avail_q;
   logic        at_last;
   logic        io_stall;

`ifdef MEM_IOBUF_STALL_EN
   assign io_stall = io_buffer_full && ((mem_a & IO_REGION) == IO_REGION);
`else
   logic unused_iobuf;
   assign unused_iobuf = io_buffer_full;
   assign io_stall     = 1'b0;
`endif

   assign at_last       = (cnt == {1'b0, last_q});
   assign cap_idx       = cnt[1:0] - 2'd1;
   assign mem_stuck     = (state != MEM_IDLE);
   assign mem_wr        = wr_q && rdy_in && !io_stall;
   assign mem_res_avail = res_avail_q;
   assign if_res_avail  = if_avail_q;

   // The final byte of a read is only on mem_din during the completion cycle itself.
   always_comb begin
      assembled = raw;
      case (last_q)
         2'd0:    assembled[7:0]   = mem_din;
         2'd1:    assembled[15:8]  = mem_din;
         default: assembled[31:24] = mem_din;
      endcase
   end

   mem_ext u_ext (
      .raw (assembled),
      .op  (op_q),
      .res (ext_res)
   );

   assign mem_res = (res_avail_q && res_load_q) ? ext_res : 32'd0;
   assign if_res  = if_avail_q ? assembled : 32'd0;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= MEM_IDLE;
         cnt         <= 3'd0;
         last_q      <= 2'd0;
         op_q        <= 3'd0;
         data_q      <= 32'd0;
         raw         <= 32'd0;
         din_vld     <= 1'b0;
         wr_q        <= 1'b0;
         kill_q      <= 1'b0;
         res_avail_q <= 1'b0;
         res_load_q  <= 1'b0;
         if_avail_q  <= 1'b0;
         mem_a       <= 32'd0;
         mem_dout    <= 8'd0;
      end else if (!rdy_in) begin
         // Keep the byte already in flight; the held address is re-read on resume and discarded.
         if (din_vld) raw[{cap_idx, 3'b000} +: 8] <= mem_din;
         din_vld <= 1'b0;
      end else begin
         res_avail_q <= 1'b0;
         if_avail_q  <= 1'b0;
         din_vld     <= 1'b0;
         if (din_vld) raw[{cap_idx, 3'b000} +: 8] <= mem_din;
         case (state)
            MEM_IDLE: begin
               cnt <= 3'd0;
               if (!rob_clear && is_io) begin
                  state  <= is_store ? MEM_STORE : MEM_LOAD;
                  mem_a  <= io_addr;
                  op_q   <= io_op;
                  last_q <= last_byte(io_op[1:0]);
                  kill_q <= 1'b0;
                  if (is_store) begin
                     mem_dout <= io_data[7:0];
                     data_q   <= io_data >> 8;
                     wr_q     <= 1'b1;
                  end
               end else if (!rob_clear && if_req) begin
                  state  <= MEM_FETCH;
                  mem_a  <= if_addr;
                  last_q <= 2'd3;
               end
            end
            MEM_LOAD, MEM_FETCH: begin
               if (rob_clear) begin
                  state <= MEM_IDLE;
               end else if (at_last) begin
                  state <= MEM_IDLE;
                  if (state == MEM_LOAD) begin
                     res_avail_q <= 1'b1;
                     res_load_q  <= 1'b1;
                  end else begin
                     if_avail_q <= 1'b1;
                  end
               end else begin
                  cnt     <= cnt + 3'd1;
                  mem_a   <= mem_a + 32'd1;
                  din_vld <= 1'b1;
               end
            end
            default: begin
               if (rob_clear) kill_q <= 1'b1;
               if (!io_stall) begin
                  if (at_last) begin
                     state       <= MEM_IDLE;
                     wr_q        <= 1'b0;
                     res_avail_q <= !(kill_q || rob_clear);
                     res_load_q  <= 1'b0;
                  end else begin
                     cnt      <= cnt + 3'd1;
                     mem_a    <= mem_a + 32'd1;
                     mem_dout <= data_q[7:0];
                     data_q   <= data_q >> 8;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: fixed vector table, hand-written corner sequences and random traffic
// checked against a byte-array memory model.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_clear;
   logic        is_io;
   logic        is_store;
   logic [31:0] io_addr;
   logic [31:0] io_data;
   logic [2:0]  io_op;
   logic        mem_res_avail;
   logic [31:0] mem_res;
   logic        mem_stuck;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_res_avail;
   logic [31:0] if_res;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   mem_ctrl dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .rob_clear      (rob_clear),
      .is_io          (is_io),
      .is_store       (is_store),
      .io_addr        (io_addr),
      .io_data        (io_data),
      .io_op          (io_op),
      .mem_res_avail  (mem_res_avail),
      .mem_res        (mem_res),
      .mem_stuck      (mem_stuck),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_res_avail   (if_res_avail),
      .if_res         (if_res),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // img is the bench's belief of memory contents; ram is the RAM the DUT talks to.
   logic [7:0] img [0:4095];
   logic [7:0] ram [0:4095];

   always @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 4096; i++) ram[i] <= img[i];
      end else begin
         mem_din <= ram[mem_a[11:0]];
         if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   int          r_av, r_ifav, r_aseq_bad;
   logic [31:0] r_res, r_ifres;
   logic        stuck_h [0:31];
   logic [31:0] wq_a [$];
   logic [7:0]  wq_d [$];
   int          wq_c [$];

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  op;
      logic [31:0] exp_res;
      int          exp_av;
   } vec_t;

   vec_t tv [13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] op);
      if (op[1:0] == 2'b00) return 1;
      if (op[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
      int          n;
      longint      v;
      logic [31:0] ai;
      n = nbytes(op);
      v = 0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         v  = v + (longint'(img[ai[11:0]]) << (8 * i));
      end
      if (n < 4 && !op[2] && v >= (longint'(1) << (8 * n - 1)))
         v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   // kind: 0 load, 1 store, 2 fetch. Inputs for cycle j are applied at its start, outputs sampled 1ns later.
   task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                         input int clr_at, input int stall_at, input int full_until,
                         input logic also_if, input logic [31:0] ifa, input int ncyc);
      int n;
      n = (kind == 2) ? 4 : nbytes(op);
      wq_a.delete(); wq_d.delete(); wq_c.delete();
      r_av = 0; r_ifav = 0; r_res = 'x; r_ifres = 'x; r_aseq_bad = 0;
      for (int j = 0; j < 32; j++) stuck_h[j] = 1'bx;
      if (kind == 2) begin
         if_req = 1'b1; if_addr = a;
      end else begin
         is_io = 1'b1; is_store = (kind == 1); io_addr = a; io_data = d; io_op = op;
      end
      if (also_if) begin
         if_req = 1'b1; if_addr = ifa;
      end
      @(posedge clk_in); #1;
      is_io = 1'b0;
      if (kind == 2) if_req = 1'b0;
      for (int j = 1; j <= ncyc; j++) begin
         rob_clear      = (j == clr_at);
         rdy_in         = (j != stall_at);
         io_buffer_full = (j <= full_until);
         if (also_if && r_av != 0 && j == r_av + 1) if_req = 1'b0;
         #1;
         stuck_h[j] = mem_stuck;
         if (mem_wr) begin
            wq_a.push_back(mem_a); wq_d.push_back(mem_dout); wq_c.push_back(j);
         end
         if (kind != 1 && stall_at == 0 && clr_at == 0 && j <= n && mem_a !== a + 32'(j - 1))
            r_aseq_bad++;
         if (mem_res_avail && r_av == 0) begin r_av = j; r_res = mem_res; end
         if (if_res_avail && r_ifav == 0) begin r_ifav = j; r_ifres = if_res; end
         @(posedge clk_in); #1;
      end
      rob_clear = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
   endtask

   task automatic check_writes(input string nm, input logic [31:0] a, input logic [31:0] d, input int n);
      int          bad;
      logic [31:0] ai;
      logic [31:0] dsh;
      check({nm, " wr_count"}, 32'(wq_a.size()), 32'(n));
      bad = 0;
      for (int i = 0; i < n && i < wq_a.size(); i++) begin
         dsh = d >> (8 * i);
         if (wq_a[i] !== a + 32'(i) || wq_d[i] !== dsh[7:0]) bad++;
      end
      check({nm, " wr_bytes"}, 32'(bad), 32'd0);
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         dsh = d >> (8 * i);
         img[ai[11:0]] = dsh[7:0];
      end
   endtask

   task automatic check_stuck(input string nm, input int lo);
      int bad;
      bad = 0;
      for (int j = 1; j < lo; j++) if (stuck_h[j] !== 1'b1) bad++;
      if (stuck_h[lo] !== 1'b0) bad++;
      check({nm, " stuck"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int          kind, n, stall, exp_av;
      logic [2:0]  op;
      logic [31:0] a, d, exp_v;

      rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; is_io = 1'b0; is_store = 1'b0;
      io_addr = '0; io_data = '0; io_op = '0; if_req = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
      for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
      img[12'h100] = 8'h80; img[12'h101] = 8'h7F; img[12'h102] = 8'h01; img[12'h103] = 8'hFF;
      for (int i = 12'h300; i < 12'h308; i++) img[i] = 8'h00;

      tv[0]  = '{0, 32'h100, 32'h0,        3'b010, 32'hFF017F80, 5};
      tv[1]  = '{0, 32'h100, 32'h0,        3'b000, 32'hFFFFFF80, 2};
      tv[2]  = '{0, 32'h100, 32'h0,        3'b100, 32'h00000080, 2};
      tv[3]  = '{0, 32'h101, 32'h0,        3'b001, 32'h0000017F, 3};
      tv[4]  = '{0, 32'h102, 32'h0,        3'b101, 32'h0000FF01, 3};
      tv[5]  = '{0, 32'h102, 32'h0,        3'b001, 32'hFFFFFF01, 3};
      tv[6]  = '{1, 32'h200, 32'hDEADBEEF, 3'b010, 32'h00000000, 5};
      tv[7]  = '{1, 32'h300, 32'hDEADBEEF, 3'b000, 32'h00000000, 2};
      tv[8]  = '{1, 32'h304, 32'h12345678, 3'b001, 32'h00000000, 3};
      tv[9]  = '{0, 32'h200, 32'h0,        3'b010, 32'hDEADBEEF, 5};
      tv[10] = '{0, 32'h300, 32'h0,        3'b010, 32'h000000EF, 5};
      tv[11] = '{0, 32'h304, 32'h0,        3'b010, 32'h00005678, 5};
      tv[12] = '{2, 32'h100, 32'h0,        3'b010, 32'hFF017F80, 5};

      repeat (3) @(posedge clk_in);
      #1;
      check("reset mem_a", mem_a, 32'd0);
      check("reset mem_res", mem_res, 32'd0);
      check("reset if_res", if_res, 32'd0);
      check("reset flags", {23'd0, mem_dout, mem_stuck, mem_wr, mem_res_avail, if_res_avail},
            32'd0);
      rst_in = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_op(tv[i].kind, tv[i].addr, tv[i].data, tv[i].op, 0, 0, 0, 1'b0, 32'd0, 10);
         if (tv[i].kind == 2) begin
            check($sformatf("vec%0d if_av_cycle", i), 32'(r_ifav), 32'(tv[i].exp_av));
            check($sformatf("vec%0d if_res", i), r_ifres, tv[i].exp_res);
         end else begin
            check($sformatf("vec%0d av_cycle", i), 32'(r_av), 32'(tv[i].exp_av));
            check($sformatf("vec%0d res", i), r_res, tv[i].exp_res);
         end
         check_stuck($sformatf("vec%0d", i), tv[i].exp_av);
         if (tv[i].kind == 1) begin
            check_writes($sformatf("vec%0d", i), tv[i].addr, tv[i].data, nbytes(tv[i].op));
            check($sformatf("vec%0d first_wr", i), 32'(wq_c.size() > 0 ? wq_c[0] : -1), 32'd1);
         end
      end

      // LSB and fetch at the same edge: LSB first, fetch accepted as the LSB pulse ends.
      run_op(0, 32'h100, 32'h0, 3'b010, 0, 0, 0, 1'b1, 32'h200, 14);
      check("prio lsb_av", 32'(r_av), 32'd5);
      check("prio lsb_res", r_res, 32'hFF017F80);
      check("prio stuck_at_av", {31'd0, stuck_h[5]}, 32'd0);
      check("prio if_av", 32'(r_ifav), 32'd10);
      check("prio if_res", r_ifres, 32'hDEADBEEF);

      run_op(0, 32'h100, 32'h0, 3'b010, 2, 0, 0, 1'b0, 32'd0, 8);
      check("flush_lw av", 32'(r_av), 32'd0);
      check("flush_lw idle_c3", {31'd0, stuck_h[3]}, 32'd0);

      run_op(1, 32'h208, 32'hCAFEF00D, 3'b010, 2, 0, 0, 1'b0, 32'd0, 8);
      check("flush_sw av", 32'(r_av), 32'd0);
      check_writes("flush_sw", 32'h208, 32'hCAFEF00D, 4);
      check_stuck("flush_sw", 5);
      run_op(0, 32'h208, 32'h0, 3'b010, 0, 0, 0, 1'b0, 32'd0, 8);
      check("after_flush_sw res", r_res, 32'hCAFEF00D);

      run_op(0, 32'h100, 32'h0, 3'b010, 0, 2, 0, 1'b0, 32'd0, 10);
      check("rdy_lw av", 32'(r_av), 32'd6);
      check("rdy_lw res", r_res, 32'hFF017F80);

      run_op(1, 32'h20C, 32'h11223344, 3'b010, 0, 3, 0, 1'b0, 32'd0, 10);
      check("rdy_sw av", 32'(r_av), 32'd6);
      check_writes("rdy_sw", 32'h20C, 32'h11223344, 4);
      check("rdy_sw third_wr_cycle", 32'(wq_c.size() > 2 ? wq_c[2] : -1), 32'd4);

      exp_v = model_load(32'hFFFFFFFE, 3'b010);
      run_op(0, 32'hFFFFFFFE, 32'h0, 3'b010, 0, 0, 0, 1'b0, 32'd0, 8);
      check("wrap res", r_res, exp_v);
      check("wrap addr_seq", 32'(r_aseq_bad), 32'd0);

      run_op(1, 32'h0003_0000, 32'h000000A5, 3'b000, 0, 0, 3, 1'b0, 32'd0, 8);
`ifdef MEM_IOBUF_STALL_EN
      check("iobuf first_wr", 32'(wq_c.size() > 0 ? wq_c[0] : -1), 32'd4);
      check("iobuf av", 32'(r_av), 32'd5);
`else
      check("iobuf first_wr", 32'(wq_c.size() > 0 ? wq_c[0] : -1), 32'd1);
      check("iobuf av", 32'(r_av), 32'd2);
`endif
      check_writes("iobuf", 32'h0003_0000, 32'h000000A5, 1);

      for (int it = 0; it < 60; it++) begin
         kind  = $urandom_range(0, 2);
         op    = {(kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 2))};
         a     = 32'($urandom_range(0, 4095));
         d     = $urandom;
         n     = (kind == 2) ? 4 : nbytes(op);
         stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
         exp_av = n + 1 + ((stall != 0) ? 1 : 0);
         exp_v = model_load(a, (kind == 2) ? 3'b010 : op);
         run_op(kind, a, d, op, 0, stall, 0, 1'b0, 32'd0, 8);
         if (kind == 2) begin
            check($sformatf("rnd%0d if_av", it), 32'(r_ifav), 32'(exp_av));
            check($sformatf("rnd%0d if_res", it), r_ifres, exp_v);
         end else begin
            check($sformatf("rnd%0d av", it), 32'(r_av), 32'(exp_av));
            check($sformatf("rnd%0d res", it), r_res, (kind == 1) ? 32'd0 : exp_v);
         end
         if (kind == 1) check_writes($sformatf("rnd%0d", it), a, d, n);
         else if (stall == 0) check($sformatf("rnd%0d addr_seq", it), 32'(r_aseq_bad), 32'd0);
      end

      // Asynchronous reset in the middle of a word load.
      is_io = 1'b1; is_store = 1'b0; io_addr = 32'h100; io_op = 3'b010;
      @(posedge clk_in); #1;
      is_io = 1'b0;
      @(posedge clk_in); #1;
      check("prerst stuck", {31'd0, mem_stuck}, 32'd1);
      #2 rst_in = 1'b1;
      #1;
      check("async_rst mem_a", mem_a, 32'd0);
      check("async_rst res", mem_res | if_res, 32'd0);
      check("async_rst flags", {23'd0, mem_dout, mem_stuck, mem_wr, mem_res_avail, if_res_avail},
            32'd0);
      @(posedge clk_in); @(posedge clk_in); #1;
      rst_in = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the load-store buffer / instruction-fetch unit and the external 8-bit RAM port. It accepts one word/half/byte load or store from the LSB, or one 32-bit instruction fetch, serialises it into byte accesses, and returns a single-cycle completion pulse with the assembled, extended result. The LSB has priority over fetch. Speculative work is aborted on ROB flush, but committed stores always finish.

## Interface
- No parameters.
- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global enable; low freezes the block
- rob_clear  in  1  flush
- is_io  in  1  LSB request (level)
- is_store  in  1  0 load, 1 store
- io_addr  in  32  byte address
- io_data  in  32  store data (low bytes used)
- io_op  in  3  funct3: [1:0] size 00 B / 01 H / 10 W; [2] unsigned load
- mem_res_avail  out  1  LSB completion pulse (loads and stores)
- mem_res  out  32  extended load data; 0 for stores
- mem_stuck  out  1  busy; the LSB must not raise is_io while high
- if_req  in  1  fetch request (level)
- if_addr  in  32  fetch address
- if_res_avail  out  1  fetch completion pulse
- if_res  out  32  fetched instruction, little-endian
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe
- io_buffer_full  in  1  UART output buffer full

## Operation
- States: IDLE, LOAD, STORE, FETCH. Byte counter cnt is 3 bits. Byte count N is 1/2/4 from io_op[1:0]; a fetch uses N=4.
- In IDLE with rdy_in=1:
  - is_io=1 → latch addr, data, op; go to LOAD or STORE.
  - Otherwise if_req=1 → latch if_addr; go to FETCH.
  - is_io wins if both are high at the same edge.
- RAM contract: mem_din in cycle k is the byte at the mem_a presented in cycle k-1.
- Byte i uses address addr+i, a 32-bit wrap-around add. Little-endian: byte i maps to result[8i+7:8i].
- Load result:
  - B: sign- or zero-extended from bit 7.
  - H: sign- or zero-extended from bit 15.
  - W: used as is.
  - Extension is selected by io_op[2].
- Store: write byte i = io_data[8i+7:8i], with mem_wr=1 for exactly N cycles.
- Final byte done → pulse the matching avail for 1 cycle and return to IDLE.
- rob_clear:
  - During LOAD or FETCH, and on any request present in that cycle: abort to IDLE at that edge, with no avail pulse and mem_wr=0.
  - During STORE: the remaining bytes are still written, and mem_stuck stays high. mem_res_avail is suppressed for that store.
- rdy_in=0: state, counter and outputs hold, except mem_wr is forced 0. On resume, a LOAD/FETCH re-presents the current byte address and discards the stale mem_din.
- Reset values: state IDLE, cnt 0, mem_a 0, mem_dout 0, mem_wr 0, mem_res 0, if_res 0, mem_res_avail 0, if_res_avail 0, mem_stuck 0.

## Timing
- Count from the accepting edge E0. Cycle j is the cycle after edge Ej.
- Load of N bytes:
  - mem_a = addr+i in cycle i+1.
  - mem_res_avail=1 and mem_res valid in cycle N+1 only.
  - Word load: avail in cycle 5.
- Store of N bytes: writes in cycles 1..N; mem_res_avail in cycle N+1.
- Fetch: if_res_avail in cycle 5.
- mem_stuck is high for cycles 1..N+... until the state returns to IDLE; it is low in the avail cycle.
- A request present in the avail cycle is accepted at the edge ending it (back-to-back, no bubble).
- Requesters deassert their request in the cycle after acceptance. While mem_stuck is high, is_io and if_req are ignored.
- Each cycle of rdy_in=0 adds one cycle to every latency above.

## Configuration
- MEM_IOBUF_STALL_EN defined: a store byte whose address satisfies addr[17:16]==2'b11 (0x30000 I/O region) is not written while io_buffer_full=1. mem_wr stays 0, cnt holds, and latency extends by the stall cycles.
- Undefined: io_buffer_full is ignored.

## Structure
- const.v holds:
  - the state encodings MEM_IDLE/MEM_LOAD/MEM_STORE/MEM_FETCH;
  - the I/O region constant 32'h30000;
  - the size codes.
- Sub-module mem_ext: a combinational byte/half sign/zero extender, taking a 32-bit raw value and io_op and producing a 32-bit result.

## Test plan
- RAM [0x100..0x103]=0x80,0x7F,0x01,0xFF; LW 0x100 → mem_res=0xFF017F80 in cycle 5, mem_stuck high cycles 1-4.
- LB 0x100 → mem_res=0xFFFFFF80 in cycle 2; LBU → 0x00000080; LH 0x101 → 0x0000017F.
- SW 0x200 data 0xDEADBEEF → writes EF,BE,AD,DE at 0x200-0x203 in cycles 1-4, avail in cycle 5; SB writes only 0xEF.
- is_io and if_req high at the same edge → LSB served first; fetch is accepted at the edge ending the LSB avail cycle, and if_res_avail follows 5 cycles later.
- rob_clear in cycle 2 of LW → no avail, IDLE next cycle; rob_clear in cycle 2 of SW → all 4 bytes written, no mem_res_avail.
- With MEM_IOBUF_STALL_EN: SB 0x30000 while io_buffer_full=1 for 3 cycles → mem_wr is first high in cycle 4, avail in cycle 5. rst_in asserted mid-load → all outputs 0 immediately (asynchronous).
